// File: rtl/nav_seq.sv
// Motion sequencer feeding the PID: handles heading changes and forward moves,
// ramping forward speed up/down in step with the PID update strobe.
module nav_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       strt_hdng,
  input  logic       strt_mv,
  input  logic       stp_lft,
  input  logic       stp_rght,
  input  logic       at_hdng,
  input  logic       lft_opn,
  input  logic       rght_opn,
  input  logic       frwrd_opn,
  input  logic       err_vld,
  output logic       moving,
  output logic [9:0] frwrd,
  output logic       mv_cmplt
);

  localparam int unsigned FRWRD_W = 10;
  localparam int unsigned EXT_W   = FRWRD_W + 1;

  localparam logic [FRWRD_W-1:0] FRWRD_MAX = 10'h2A0;
  localparam logic [FRWRD_W-1:0] RAMP_INC  = 10'h010;
  localparam logic [EXT_W-1:0]   DEC_NRM   = {1'b0, RAMP_INC} << 1;
  localparam logic [EXT_W-1:0]   DEC_EMG   = {1'b0, RAMP_INC} << 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDNG  = 2'd1,
    S_ACCEL = 2'd2,
    S_DECEL = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_nxt_state;
  logic [FRWRD_W-1:0]   r_frwrd;
  logic [FRWRD_W-1:0]   w_nxt_frwrd;
  logic                 r_emerg;
  logic                 w_nxt_emerg;
  logic                 r_mv_cmplt;
  logic                 w_nxt_cmplt;
  logic                 r_moving;
  logic                 r_lft_q;
  logic                 r_rght_q;

  logic                 w_side_stop;
  logic                 w_emerg_eff;
  logic [EXT_W-1:0]     w_inc_sum;
  logic [FRWRD_W-1:0]   w_inc_sat;
  logic [EXT_W-1:0]     w_dec_amt;
  logic [FRWRD_W-1:0]   w_dec_sat;
  logic                 w_decel_done;

  // Only a fresh opening on an armed side ends the move.
  assign w_side_stop = (stp_lft  && lft_opn  && !r_lft_q) ||
                       (stp_rght && rght_opn && !r_rght_q);

  // Saturating speed arithmetic on an 11-bit intermediate so nothing wraps.
  assign w_inc_sum   = {1'b0, r_frwrd} + {1'b0, RAMP_INC};
  assign w_inc_sat   = (w_inc_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX
                                                       : w_inc_sum[FRWRD_W-1:0];
  assign w_emerg_eff = r_emerg || !frwrd_opn;
  assign w_dec_amt   = w_emerg_eff ? DEC_EMG : DEC_NRM;
  assign w_dec_sat   = ({1'b0, r_frwrd} > w_dec_amt)
                       ? (r_frwrd - w_dec_amt[FRWRD_W-1:0])
                       : '0;

  assign w_decel_done = (r_frwrd == '0) || (err_vld && (w_dec_sat == '0));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_frwrd    <= '0;
      r_emerg    <= 1'b0;
      r_mv_cmplt <= 1'b0;
      r_moving   <= 1'b0;
      r_lft_q    <= 1'b0;
      r_rght_q   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_frwrd    <= w_nxt_frwrd;
      r_emerg    <= w_nxt_emerg;
      r_mv_cmplt <= w_nxt_cmplt;
      r_moving   <= (w_nxt_state != S_IDLE);
      r_lft_q    <= lft_opn;
      r_rght_q   <= rght_opn;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (strt_hdng)    w_nxt_state = S_HDNG;
        else if (strt_mv) w_nxt_state = S_ACCEL;
      end
      S_HDNG: begin
        if (at_hdng) w_nxt_state = S_IDLE;
      end
      S_ACCEL: begin
        if (!frwrd_opn || w_side_stop) w_nxt_state = S_DECEL;
      end
      S_DECEL: begin
        if (w_decel_done) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Speed, emergency flag and completion pulse.
  always_comb begin
    w_nxt_frwrd = r_frwrd;
    w_nxt_emerg = r_emerg;
    w_nxt_cmplt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_frwrd = '0;
        w_nxt_emerg = 1'b0;
      end
      S_HDNG: begin
        w_nxt_frwrd = '0;
        if (at_hdng) w_nxt_cmplt = 1'b1;
      end
      S_ACCEL: begin
        // A stop condition pre-empts any ramp step in the same cycle.
        if (!frwrd_opn)       w_nxt_emerg = 1'b1;
        else if (w_side_stop) w_nxt_emerg = 1'b0;
        else if (err_vld)     w_nxt_frwrd = w_inc_sat;
      end
      S_DECEL: begin
        if (w_decel_done) begin
          w_nxt_frwrd = '0;
          w_nxt_emerg = 1'b0;
          w_nxt_cmplt = 1'b1;
        end else begin
          w_nxt_emerg = w_emerg_eff;
          if (err_vld) w_nxt_frwrd = w_dec_sat;
        end
      end
      default: begin
        w_nxt_frwrd = '0;
        w_nxt_emerg = 1'b0;
      end
    endcase
  end

  assign moving   = r_moving;
  assign frwrd    = r_frwrd;
  assign mv_cmplt = r_mv_cmplt;

endmodule

// File: tb/tb_nav_seq.sv
// Self-checking bench for nav_seq: vector table, directed ramp/stop/reset
// sequences, and randomized stimulus against a behavioural model.
module tb_nav_seq;

  logic       clk;
  logic       rst;
  logic       strt_hdng;
  logic       strt_mv;
  logic       stp_lft;
  logic       stp_rght;
  logic       at_hdng;
  logic       lft_opn;
  logic       rght_opn;
  logic       frwrd_opn;
  logic       err_vld;
  logic       moving;
  logic [9:0] frwrd;
  logic       mv_cmplt;

  int n_checks = 0;
  int n_fail   = 0;

  nav_seq dut (
    .clk      (clk),
    .rst      (rst),
    .strt_hdng(strt_hdng),
    .strt_mv  (strt_mv),
    .stp_lft  (stp_lft),
    .stp_rght (stp_rght),
    .at_hdng  (at_hdng),
    .lft_opn  (lft_opn),
    .rght_opn (rght_opn),
    .frwrd_opn(frwrd_opn),
    .err_vld  (err_vld),
    .moving   (moving),
    .frwrd    (frwrd),
    .mv_cmplt (mv_cmplt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 heading, 2 speeding up, 3 slowing down.
  int m_mode;
  int m_frwrd;
  bit m_emerg;
  bit m_cmplt;
  bit m_lprev;
  bit m_rprev;

  task automatic model_reset();
    m_mode  = 0;
    m_frwrd = 0;
    m_emerg = 0;
    m_cmplt = 0;
    m_lprev = 0;
    m_rprev = 0;
  endtask

  task automatic model_step();
    bit rise_l, rise_r, emg;
    int nf;
    rise_l  = lft_opn && !m_lprev;
    rise_r  = rght_opn && !m_rprev;
    m_cmplt = 0;
    case (m_mode)
      0: begin
        if (strt_hdng)    m_mode = 1;
        else if (strt_mv) m_mode = 2;
      end
      1: begin
        if (at_hdng) begin m_mode = 0; m_cmplt = 1; end
      end
      2: begin
        if (!frwrd_opn) begin
          m_mode = 3; m_emerg = 1;
        end else if ((rise_l && stp_lft) || (rise_r && stp_rght)) begin
          m_mode = 3; m_emerg = 0;
        end else if (err_vld) begin
          m_frwrd = (m_frwrd + 16 > 672) ? 672 : m_frwrd + 16;
        end
      end
      default: begin
        emg = m_emerg || !frwrd_opn;
        nf  = m_frwrd;
        if (err_vld) begin
          nf = m_frwrd - (emg ? 64 : 32);
          if (nf < 0) nf = 0;
        end
        if (m_frwrd == 0 || nf == 0) begin
          m_mode = 0; m_frwrd = 0; m_emerg = 0; m_cmplt = 1;
        end else begin
          m_frwrd = nf; m_emerg = emg;
        end
      end
    endcase
    m_lprev = lft_opn;
    m_rprev = rght_opn;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic em, input logic [9:0] ef, input logic ec);
    check({tag, ".moving"},   32'(moving),   32'(em));
    check({tag, ".frwrd"},    32'(frwrd),    32'(ef));
    check({tag, ".mv_cmplt"}, 32'(mv_cmplt), 32'(ec));
  endtask

  // One clock: DUT and model both see the inputs held since the last falling edge.
  task automatic tick(input bit use_model);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (use_model)
      check_out("model", 1'(m_mode != 0), 10'(m_frwrd), 1'(m_cmplt));
  endtask

  task automatic quiet_inputs();
    strt_hdng = 0; strt_mv = 0; stp_lft = 0; stp_rght = 0; at_hdng = 0;
    lft_opn = 0; rght_opn = 0; frwrd_opn = 1; err_vld = 0;
  endtask

  task automatic pulses(input int n);
    err_vld = 1;
    for (int i = 0; i < n; i++) tick(1'b0);
    err_vld = 0;
  endtask

  typedef struct packed {
    logic       sh, sm, sl, sr, ah, lo, ro, fo, ev;
    logic       em;
    logic [9:0] ef;
    logic       ec;
  } vec_t;

  vec_t tbl [23];

  initial begin
    //            sh sm sl sr ah lo ro fo ev   em  ef       ec
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 10'h000, 1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0, 10'h000, 1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1, 10'h000, 1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1, 10'h010, 1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1, 10'h020, 1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1, 10'h020, 1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1, 10'h020, 1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b0, 10'h000, 1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0, 10'h000, 1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1, 10'h000, 1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1, 10'h000, 1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0, 10'h000, 1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0, 10'h000, 1'b0};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, 10'h000, 1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1, 10'h000, 1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0, 10'h000, 1'b1};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 10'h000, 1'b0};
    tbl[17] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1, 10'h000, 1'b0};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1, 10'h010, 1'b0};
    tbl[19] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1, 10'h010, 1'b0};
    tbl[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1, 10'h010, 1'b0};
    tbl[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0, 10'h000, 1'b1};
    tbl[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 10'h000, 1'b0};

    quiet_inputs();
    model_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 10'h000, 1'b0);
    rst = 0;

    // Vector table
    for (int i = 0; i < 23; i++) begin
      {strt_hdng, strt_mv, stp_lft, stp_rght, at_hdng, lft_opn, rght_opn, frwrd_opn, err_vld}
        = {tbl[i].sh, tbl[i].sm, tbl[i].sl, tbl[i].sr, tbl[i].ah,
           tbl[i].lo, tbl[i].ro, tbl[i].fo, tbl[i].ev};
      tick(1'b0);
      check_out($sformatf("vec%0d", i), tbl[i].em, tbl[i].ef, tbl[i].ec);
    end
    quiet_inputs();

    // Full ramp to saturation, then normal stop on a fresh left opening
    strt_mv = 1; tick(1'b0); strt_mv = 0;
    err_vld = 1;
    for (int k = 1; k <= 50; k++) begin
      tick(1'b0);
      check_out($sformatf("ramp%0d", k), 1'b1, 10'((k * 16 > 672) ? 672 : k * 16), 1'b0);
    end
    err_vld = 0;
    stp_lft = 1; lft_opn = 1; tick(1'b0);
    check_out("lstop", 1'b1, 10'h2A0, 1'b0);
    err_vld = 1;
    for (int k = 1; k <= 21; k++) begin
      tick(1'b0);
      if (k < 21) check_out($sformatf("ndec%0d", k), 1'b1, 10'(672 - 32 * k), 1'b0);
      else        check_out("ndec_done", 1'b0, 10'h000, 1'b1);
    end
    err_vld = 0; tick(1'b0);
    check_out("ndec_after", 1'b0, 10'h000, 1'b0);
    quiet_inputs();

    // Emergency stop from full speed
    strt_mv = 1; tick(1'b0); strt_mv = 0;
    pulses(42);
    check_out("emax", 1'b1, 10'h2A0, 1'b0);
    frwrd_opn = 0; tick(1'b0);
    check_out("eblock", 1'b1, 10'h2A0, 1'b0);
    err_vld = 1;
    for (int k = 1; k <= 11; k++) begin
      tick(1'b0);
      if (k < 11) check_out($sformatf("edec%0d", k), 1'b1, 10'(672 - 64 * k), 1'b0);
      else        check_out("edec_done", 1'b0, 10'h000, 1'b1);
    end
    quiet_inputs(); tick(1'b0);
    check_out("edec_after", 1'b0, 10'h000, 1'b0);

    // Opening present at move start is ignored until it re-appears
    lft_opn = 1; stp_lft = 1; tick(1'b0);
    strt_mv = 1; tick(1'b0); strt_mv = 0;
    pulses(5);
    check_out("preopen", 1'b1, 10'h050, 1'b0);
    lft_opn = 0; tick(1'b0);
    check_out("lft_low", 1'b1, 10'h050, 1'b0);
    lft_opn = 1; tick(1'b0);
    check_out("lft_rise", 1'b1, 10'h050, 1'b0);
    pulses(2);
    check_out("pdec2", 1'b1, 10'h010, 1'b0);
    err_vld = 1; tick(1'b0); err_vld = 0;
    check_out("pdec_done", 1'b0, 10'h000, 1'b1);
    quiet_inputs(); tick(1'b0);

    // Asynchronous reset in the middle of a ramp
    strt_mv = 1; tick(1'b0); strt_mv = 0;
    pulses(21);
    check_out("pre_rst", 1'b1, 10'h150, 1'b0);
    rst = 1; #1;
    check_out("async_rst", 1'b0, 10'h000, 1'b0);
    model_reset();
    @(negedge clk); rst = 0;
    tick(1'b0);
    check_out("post_rst", 1'b0, 10'h000, 1'b0);
    strt_mv = 1; tick(1'b0); strt_mv = 0;
    pulses(1);
    check_out("reramp", 1'b1, 10'h010, 1'b0);
    pulses(3);
    frwrd_opn = 0; tick(1'b0);
    quiet_inputs();
    err_vld = 1; tick(1'b0); err_vld = 0;
    check_out("rr_edec", 1'b0, 10'h000, 1'b1);
    tick(1'b0);

    // Randomized traffic against the behavioural model
    for (int c = 0; c < 3000; c++) begin
      strt_hdng = ($urandom_range(0, 19) == 0);
      strt_mv   = ($urandom_range(0, 7) == 0);
      at_hdng   = ($urandom_range(0, 7) == 0);
      err_vld   = ($urandom_range(0, 3) != 0);
      frwrd_opn = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 31) == 0) stp_lft  = ~stp_lft;
      if ($urandom_range(0, 31) == 0) stp_rght = ~stp_rght;
      if ($urandom_range(0, 11) == 0) lft_opn  = ~lft_opn;
      if ($urandom_range(0, 11) == 0) rght_opn = ~rght_opn;
      tick(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
